prod_acc: RTL and testbench



---
 rtl/prod_acc_pkg.sv | 15 +
 rtl/prod_acc_sat_add.sv | 29 ++
 rtl/prod_acc.sv | 103 ++++++++++
 tb/tb_prod_acc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared types and default sizing for the product accumulator.
package prod_acc_pkg;

  // Accumulator FSM: collecting beats, or holding a finished frame sum.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned DEF_PROD_W = 16;
  localparam int unsigned DEF_N      = 8;
  localparam int unsigned DEF_ACC_W  = 19;
  localparam int unsigned FRM_CNT_W  = 8;

endpackage

// File: rtl/prod_acc_sat_add.sv
// sat_add: unsigned A_W + B_W adder with carry-out of bit A_W-1.
// With PROD_ACC_SAT_EN defined the result clamps to all-ones on carry;
// otherwise it wraps modulo 2^A_W.
module sat_add
  import prod_acc_pkg::*;
#(
  parameter int unsigned A_W = DEF_ACC_W,
  parameter int unsigned B_W = DEF_PROD_W
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           carry
);

  logic [A_W:0] full;

  // Zero-extended add one bit wider than the accumulator to expose the carry.
  always_comb begin
    full  = {1'b0, a} + (A_W + 1)'(b);
    carry = full[A_W];
`ifdef PROD_ACC_SAT_EN
    sum   = carry ? {A_W{1'b1}} : full[A_W-1:0];
`else
    sum   = full[A_W-1:0];
`endif
  end

endmodule

// File: rtl/prod_acc.sv
// prod_acc: sums frames of N unsigned products and presents each total on a
// held valid/ready output. Optional clamping: PROD_ACC_SAT_EN.
module prod_acc
  import prod_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned N      = DEF_N,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PROD_W-1:0]    in_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 out_ovf,
  output logic [FRM_CNT_W-1:0] frm_cnt
);

  localparam int unsigned CNT_W = $clog2(N);

  state_t               state_q;
  logic [ACC_W-1:0]     sum_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic [ACC_W-1:0]     out_sum_q;
  logic                 out_ovf_q;
  logic [FRM_CNT_W-1:0] frm_cnt_q;

  logic [ACC_W-1:0]     add_sum;
  logic                 add_carry;
  logic                 beat;
  logic                 last;

  sat_add #(
    .A_W (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .a     (sum_q),
    .b     (in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Handshake outputs come from registered state only.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign frm_cnt   = frm_cnt_q;

  assign beat = in_valid & in_ready;
  assign last = (cnt_q == CNT_W'(N - 1));

  // Frame FSM: accumulate N beats, then hold the total until delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      sum_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      frm_cnt_q <= '0;
    end else if (clr) begin
      // Abort: drop partial frame and any undelivered sum, keep out_sum.
      state_q <= ACC;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (beat) begin
            if (last) begin
              out_sum_q <= add_sum;
              out_ovf_q <= ovf_q | add_carry;
              sum_q     <= '0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
              state_q   <= HOLD;
            end else begin
              sum_q <= add_sum;
              cnt_q <= cnt_q + CNT_W'(1);
              ovf_q <= ovf_q | add_carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            frm_cnt_q <= frm_cnt_q + FRM_CNT_W'(1);
            state_q   <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_acc.sv
// tb_prod_acc: randomized scoreboard bench for prod_acc at ACC_W=19 and ACC_W=16.
module tb_prod_acc;

  localparam int unsigned NB  = 8;
  localparam int unsigned AWA = 19;
  localparam int unsigned AWB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_prod = '0;

  logic           a_in_ready, a_out_valid, a_out_ovf;
  logic [AWA-1:0] a_out_sum;
  logic [7:0]     a_frm;
  logic           b_in_ready, b_out_valid, b_out_ovf;
  logic [AWB-1:0] b_out_sum;
  logic [7:0]     b_frm;

  prod_acc #(.PROD_W(16), .N(NB), .ACC_W(AWA)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .frm_cnt(a_frm)
  );

  prod_acc #(.PROD_W(16), .N(NB), .ACC_W(AWB)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .frm_cnt(b_frm)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint s_a;
    bit     o_a;
    longint s_b;
    bit     o_b;
  } exp_t;

  exp_t       exp_q[$];
  longint     beats[$];
  longint     m_total;
  bit         m_hold = 1'b0;
  logic [7:0] m_frm = '0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of a frame whose true (unbounded) total is known.
  function automatic exp_t frame_result(input longint total);
    exp_t   e;
    longint lim_a = longint'(1) << AWA;
    longint lim_b = longint'(1) << AWB;
`ifdef PROD_ACC_SAT_EN
    e.s_a = (total >= lim_a) ? lim_a - 1 : total;
    e.s_b = (total >= lim_b) ? lim_b - 1 : total;
`else
    e.s_a = total % lim_a;
    e.s_b = total % lim_b;
`endif
    e.o_a = (total >= lim_a);
    e.o_b = (total >= lim_b);
    return e;
  endfunction

  // Reference model: a list of accepted beats per frame and a holding flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats.delete();
      exp_q.delete();
      m_hold <= 1'b0;
      m_frm  <= '0;
    end else if (clr) begin
      beats.delete();
      m_hold <= 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        beats.push_back(longint'(in_prod));
        if (beats.size() == NB) begin
          m_total = 0;
          foreach (beats[i]) m_total += beats[i];
          exp_q.push_back(frame_result(m_total));
          beats.delete();
          m_hold <= 1'b1;
        end
      end
    end else if (out_ready) begin
      m_frm  <= m_frm + 8'd1;
      m_hold <= 1'b0;
    end
  end

  // Monitor: handshake/frame-count checks every cycle, sum checks while valid.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", longint'(a_in_ready), longint'(!m_hold));
      check("out_valid", longint'(a_out_valid), longint'(m_hold));
      check("frm_cnt", longint'(a_frm), longint'(m_frm));
      check("in_ready16", longint'(b_in_ready), longint'(!m_hold));
      check("out_valid16", longint'(b_out_valid), longint'(m_hold));
      check("frm_cnt16", longint'(b_frm), longint'(m_frm));
      if (a_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard: got out_valid=1 expected no pending sum at %0t", $time);
        end else begin
          check("out_sum", longint'(a_out_sum), exp_q[0].s_a);
          check("out_ovf", longint'(a_out_ovf), longint'(exp_q[0].o_a));
          check("out_sum16", longint'(b_out_sum), exp_q[0].s_b);
          check("out_ovf16", longint'(b_out_ovf), longint'(exp_q[0].o_b));
          if (out_ready || clr) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Send n beats of val, holding each beat until the DUT accepts it.
  task automatic send(input int n, input logic [15:0] val, input bit rdy);
    for (int k = 0; k < n; k++) begin
      bit acc = 1'b0;
      in_valid  = 1'b1;
      in_prod   = val;
      out_ready = rdy;
      for (int t = 0; t < 40 && !acc; t++) begin
        acc = a_in_ready;
        cyc();
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready=0 expected beat accepted");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_sum"}, longint'(a_out_sum), 0);
    check({tag, "_out_ovf"}, longint'(a_out_ovf), 0);
    check({tag, "_in_ready"}, longint'(a_in_ready), 1);
    check({tag, "_out_valid"}, longint'(a_out_valid), 0);
    check({tag, "_frm_cnt"}, longint'(a_frm), 0);
    check({tag, "_out_sum16"}, longint'(b_out_sum), 0);
    check({tag, "_out_ovf16"}, longint'(b_out_ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) cyc();
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Basic frame, then a frame that overflows only the 16-bit instance.
    send(8, 16'd1000, 1'b1);
    send(8, 16'd65025, 1'b1);
    cyc();

    // Hold the result for 5 cycles while new data is offered.
    send(8, 16'd4321, 1'b0);
    in_valid = 1'b1;
    in_prod  = 16'd777;
    for (int k = 0; k < 5; k++) begin
      check("hold_in_ready", longint'(a_in_ready), 0);
      cyc();
    end
    out_ready = 1'b1;
    send(8, 16'd777, 1'b1);
    cyc();

    // Partial frame, clear coinciding with a beat, then a fresh frame.
    send(3, 16'd10, 1'b1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 16'd10;
    cyc();
    clr      = 1'b0;
    in_valid = 1'b0;
    send(8, 16'd2, 1'b1);
    cyc();

    // Asynchronous reset mid-frame (cnt=5).
    send(5, 16'd3000, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    send(8, 16'd50000, 1'b1);
    cyc();

    // Asynchronous reset while holding an undelivered sum.
    send(8, 16'd1234, 1'b0);
    cyc();
    check("hold_before_rst", longint'(a_out_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    send(8, 16'd9, 1'b1);
    cyc();

    // Randomized traffic with backpressure, bubbles and occasional clears.
    for (int k = 0; k < 500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 39) == 0);
      cyc();
    end

    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    check("drained", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
